// File: rtl/m1_wt_ctrl.sv
// SHA-256 message-schedule sequencer: rounds 0..15 forward message words, rounds 16..NUM_ROUNDS-1 expand from register taps.
// Latency: W_t is combinational from msg_word or the register taps; first W_t is valid 1 cycle after start; 1 word/cycle sustained.
// Backpressure: i_wt_ready=0 holds state, round and register (no shift); o_w_in/o_wt stay stable while o_wt_valid is high.
//
// Ports:
//   i_clk_h, i_rst_n            clock, async active-low reset
//   i_start, i_abort            begin a block (IDLE only) / synchronous cancel
//   i_msg_word/_valid, o_msg_ready   message word stream from block buffer
//   i_w14_t_2, i_w9_t_7, i_w1_t_15, i_w0_t_16   schedule register taps W[t-2], W[t-7], W[t-15], W[t-16]
//   o_wt_reg_en, o_w_in         shift enable and shift-in word for the schedule register
//   o_wt, o_wt_valid, i_wt_ready     W_t stream to the compression engine
//   o_round, o_busy, o_done     current t, non-idle flag, end-of-block pulse
module m1_wt_ctrl #(
  parameter int NUM_ROUNDS = 64
) (
  input  logic        i_clk_h,
  input  logic        i_rst_n,
  input  logic        i_start,
  input  logic        i_abort,
  input  logic [31:0] i_msg_word,
  input  logic        i_msg_valid,
  output logic        o_msg_ready,
  input  logic [31:0] i_w14_t_2,
  input  logic [31:0] i_w9_t_7,
  input  logic [31:0] i_w1_t_15,
  input  logic [31:0] i_w0_t_16,
  output logic        o_wt_reg_en,
  output logic [31:0] o_w_in,
  output logic [31:0] o_wt,
  output logic        o_wt_valid,
  input  logic        i_wt_ready,
  output logic [5:0]  o_round,
  output logic        o_busy,
  output logic        o_done
);

  localparam logic [5:0] LAST_ROUND = 6'(NUM_ROUNDS - 1);
  localparam logic [5:0] LOAD_LAST  = 6'd15;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOAD   = 2'd1,
    S_EXPAND = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [5:0]  r_round;
  logic [5:0]  w_round_nxt;
  logic        r_done;
  logic        w_done_nxt;
  logic        w_fire;
  logic [31:0] w_sig0;
  logic [31:0] w_sig1;
  logic [31:0] w_expand;

  // Expansion word from the current register taps; sums wrap mod 2^32.
  always_comb begin
    w_sig0 = {i_w1_t_15[6:0],  i_w1_t_15[31:7]}  ^
             {i_w1_t_15[17:0], i_w1_t_15[31:18]} ^
             (i_w1_t_15 >> 3);
    w_sig1 = {i_w14_t_2[16:0], i_w14_t_2[31:17]} ^
             {i_w14_t_2[18:0], i_w14_t_2[31:19]} ^
             (i_w14_t_2 >> 10);
    w_expand = w_sig1 + i_w9_t_7 + w_sig0 + i_w0_t_16;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_round_nxt = r_round;
    w_done_nxt  = 1'b0;
    o_w_in      = '0;
    o_wt_valid  = 1'b0;
    o_msg_ready = 1'b0;

    case (r_state)
      S_LOAD: begin
        o_w_in      = i_msg_word;
        o_wt_valid  = i_msg_valid;
        // Buffer sees consumption only when the engine takes the word;
        // abort suppresses it so no message word is lost silently.
        o_msg_ready = i_wt_ready & ~i_abort;
      end
      S_EXPAND: begin
        o_w_in     = w_expand;
        o_wt_valid = 1'b1;
      end
      default: begin
      end
    endcase

    w_fire = o_wt_valid & i_wt_ready & ~i_abort;

    if (r_state == S_IDLE) begin
      // abort has priority over start while idle
      if (i_start && !i_abort) begin
        w_state_nxt = S_LOAD;
        w_round_nxt = '0;
      end
    end else if (i_abort) begin
      w_state_nxt = S_IDLE;
      w_round_nxt = '0;
    end else if (w_fire) begin
      if (r_round == LAST_ROUND) begin
        w_state_nxt = S_IDLE;
        w_round_nxt = '0;
        w_done_nxt  = 1'b1;
      end else begin
        w_round_nxt = r_round + 6'd1;
        if (r_state == S_LOAD && r_round == LOAD_LAST) begin
          w_state_nxt = S_EXPAND;
        end
      end
    end
  end

  always_ff @(posedge i_clk_h or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_round <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_round <= w_round_nxt;
      r_done  <= w_done_nxt;
    end
  end

  assign o_wt        = o_w_in;
  assign o_wt_reg_en = w_fire;
  assign o_round     = r_round;
  assign o_busy      = (r_state != S_IDLE);
  assign o_done      = r_done;

endmodule

// File: tb/tb_m1_wt_ctrl.sv
// Bench for m1_wt_ctrl: models the external 16-stage schedule register and
// checks every presented W_t against a message-schedule recurrence model.
// Latency/backpressure behaviour are exercised with random wt_ready/msg_valid.
module tb_m1_wt_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0, abort = 1'b0, msg_valid = 1'b0, wt_ready = 1'b0;
  logic [31:0] msg_word = '0;
  logic        msg_ready, wt_reg_en, wt_valid, busy, done;
  logic [31:0] w_in, wt;
  logic [5:0]  round;
  logic [31:0] sr [16] = '{default: '0};

  logic        s_start = 1'b0, s_abort = 1'b0, s_msg_valid = 1'b0, s_wt_ready = 1'b0;
  logic [31:0] s_msg_word = '0;
  logic        s_msg_ready, s_wt_reg_en, s_wt_valid, s_busy, s_done;
  logic [31:0] s_w_in, s_wt;
  logic [5:0]  s_round;
  logic [31:0] s_sr [16] = '{default: '0};

  int n_total = 0;
  int n_bad   = 0;
  logic [31:0] ref_m [16];
  logic [31:0] ref_w [64];
  logic [31:0] obs_w [64];

  always #5 clk = ~clk;

  m1_wt_ctrl #(.NUM_ROUNDS(64)) dut (
    .i_clk_h(clk), .i_rst_n(rst_n), .i_start(start), .i_abort(abort),
    .i_msg_word(msg_word), .i_msg_valid(msg_valid), .o_msg_ready(msg_ready),
    .i_w14_t_2(sr[14]), .i_w9_t_7(sr[9]), .i_w1_t_15(sr[1]), .i_w0_t_16(sr[0]),
    .o_wt_reg_en(wt_reg_en), .o_w_in(w_in), .o_wt(wt), .o_wt_valid(wt_valid),
    .i_wt_ready(wt_ready), .o_round(round), .o_busy(busy), .o_done(done)
  );

  m1_wt_ctrl #(.NUM_ROUNDS(17)) dut17 (
    .i_clk_h(clk), .i_rst_n(rst_n), .i_start(s_start), .i_abort(s_abort),
    .i_msg_word(s_msg_word), .i_msg_valid(s_msg_valid), .o_msg_ready(s_msg_ready),
    .i_w14_t_2(s_sr[14]), .i_w9_t_7(s_sr[9]), .i_w1_t_15(s_sr[1]), .i_w0_t_16(s_sr[0]),
    .o_wt_reg_en(s_wt_reg_en), .o_w_in(s_w_in), .o_wt(s_wt), .o_wt_valid(s_wt_valid),
    .i_wt_ready(s_wt_ready), .o_round(s_round), .o_busy(s_busy), .o_done(s_done)
  );

  // External schedule registers: stage 15 newest, stage 0 oldest.
  always @(posedge clk) begin
    if (wt_reg_en) begin
      for (int i = 0; i < 15; i++) sr[i] <= sr[i+1];
      sr[15] <= w_in;
    end
    if (s_wt_reg_en) begin
      for (int i = 0; i < 15; i++) s_sr[i] <= s_sr[i+1];
      s_sr[15] <= s_w_in;
    end
  end

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Reference schedule: W[t] = M[t] for t<16, else the standard recurrence.
  task automatic build_ref();
    logic [31:0] s0, s1;
    for (int t = 0; t < 16; t++) ref_w[t] = ref_m[t];
    for (int t = 16; t < 64; t++) begin
      s0 = rotr(ref_w[t-15], 7) ^ rotr(ref_w[t-15], 18) ^ (ref_w[t-15] >> 3);
      s1 = rotr(ref_w[t-2], 17) ^ rotr(ref_w[t-2], 19) ^ (ref_w[t-2] >> 10);
      ref_w[t] = s1 + ref_w[t-7] + s0 + ref_w[t-16];
    end
  endtask

  task automatic load_msg(input bit use_abc);
    for (int i = 0; i < 16; i++) ref_m[i] = use_abc ? 32'h0 : $urandom;
    if (use_abc) begin
      ref_m[0]  = 32'h61626380;
      ref_m[15] = 32'h00000018;
    end
    build_ref();
  endtask

  // Drives one block. mode: 0 ready always, 1 ready toggles, 2 random ready.
  // gap_round: msg_valid low 5 cycles at that round; abort_round / rst_round
  // cut the block at that round; hold_start keeps start high throughout.
  task automatic run_block(input int mode, input int gap_round, input int abort_round,
                           input int rst_round, input bit hold_start, input bit use_abc);
    int k, cycles, gap, en_cnt;
    bit rdy, mv, ab, exp_valid, exp_fire, stall_prev;
    logic [31:0] prev_wt;
    load_msg(use_abc);
    for (int i = 0; i < 64; i++) obs_w[i] = '0;
    @(negedge clk);
    start = 1'b1; abort = 1'b0; msg_valid = 1'b0; wt_ready = 1'b0;
    #1;
    n_total++;
    if (busy !== 1'b0) begin n_bad++; $display("FAIL idle_before_start: busy=%b want 0", busy); end
    @(negedge clk);
    if (!hold_start) start = 1'b0;
    k = 0; cycles = 0; gap = 0; en_cnt = 0; stall_prev = 1'b0; prev_wt = '0;
    while (k < 64 && cycles < 2000) begin
      rdy = (mode == 0) ? 1'b1 : (mode == 1) ? (cycles % 2 == 0) : 1'($urandom_range(0, 1));
      ab  = (k == abort_round);
      if (ab) rdy = 1'b1;
      mv = 1'b1;
      if (k == gap_round && gap < 5) begin mv = 1'b0; gap++; end
      else if (mode == 2 && gap_round < 0 && k < 16) mv = ($urandom_range(0, 3) != 0);
      wt_ready = rdy; msg_valid = mv; abort = ab;
      msg_word = (k < 16) ? ref_m[k] : $urandom;
      if (k == rst_round) begin
        #1 rst_n = 1'b0;
        #1;
        n_total++;
        if ({busy, done, wt_valid, wt_reg_en, msg_ready} !== 5'b0 || round !== 6'd0 || wt !== 32'd0) begin
          n_bad++;
          $display("FAIL reset_mid: busy=%b done=%b vld=%b en=%b rdy=%b round=%0d wt=%h want all 0",
                   busy, done, wt_valid, wt_reg_en, msg_ready, round, wt);
        end
        @(negedge clk);
        rst_n = 1'b1; msg_valid = 1'b0; start = 1'b0;
        #1;
        n_total++;
        if (done !== 1'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL reset_no_done: done=%b busy=%b want 0 0", done, busy); end
        return;
      end
      #1;
      exp_valid = (k < 16) ? mv : 1'b1;
      exp_fire  = exp_valid && rdy && !ab;
      n_total++;
      if (busy !== 1'b1 || round !== 6'(k)) begin n_bad++; $display("FAIL round: busy=%b round=%0d want 1 %0d", busy, round, k); end
      n_total++;
      if (wt_valid !== exp_valid) begin n_bad++; $display("FAIL wt_valid t=%0d: got %b want %b", k, wt_valid, exp_valid); end
      n_total++;
      if (msg_ready !== ((k < 16) && rdy && !ab)) begin n_bad++; $display("FAIL msg_ready t=%0d: got %b want %b", k, msg_ready, (k < 16) && rdy && !ab); end
      n_total++;
      if (wt_reg_en !== exp_fire) begin n_bad++; $display("FAIL reg_en t=%0d: got %b want %b", k, wt_reg_en, exp_fire); end
      n_total++;
      if (done !== 1'b0) begin n_bad++; $display("FAIL done_early t=%0d: got %b want 0", k, done); end
      if (exp_valid) begin
        n_total++;
        if (wt !== ref_w[k] || w_in !== ref_w[k]) begin n_bad++; $display("FAIL W t=%0d: wt=%h w_in=%h want %h", k, wt, w_in, ref_w[k]); end
        if (stall_prev) begin
          n_total++;
          if (wt !== prev_wt) begin n_bad++; $display("FAIL stall_stable t=%0d: got %h want %h", k, wt, prev_wt); end
        end
      end
      stall_prev = exp_valid && !exp_fire;
      prev_wt = wt;
      if (ab) begin
        @(negedge clk);
        abort = 1'b0; msg_valid = 1'b0;
        #1;
        n_total++;
        if (busy !== 1'b0 || round !== 6'd0 || done !== 1'b0) begin n_bad++; $display("FAIL abort: busy=%b round=%0d done=%b want 0 0 0", busy, round, done); end
        @(negedge clk);
        #1;
        n_total++;
        if (done !== 1'b0) begin n_bad++; $display("FAIL abort_no_done: got %b want 0", done); end
        return;
      end
      if (wt_reg_en === 1'b1) en_cnt++;
      if (exp_fire) begin obs_w[k] = wt; k++; end
      @(negedge clk);
      cycles++;
    end
    n_total++;
    if (cycles >= 2000) begin n_bad++; $display("FAIL block_timeout: fires=%0d want 64", k); end
    #1;
    n_total++;
    if (done !== 1'b1 || busy !== 1'b0 || round !== 6'd0 || wt_valid !== 1'b0) begin
      n_bad++; $display("FAIL done_cycle: done=%b busy=%b round=%0d vld=%b want 1 0 0 0", done, busy, round, wt_valid);
    end
    n_total++;
    if (en_cnt !== 64) begin n_bad++; $display("FAIL en_count: got %0d want 64", en_cnt); end
    if (hold_start) begin
      @(negedge clk);
      #1;
      n_total++;
      if (busy !== 1'b1 || round !== 6'd0 || done !== 1'b0) begin n_bad++; $display("FAIL restart_in_done: busy=%b round=%0d done=%b want 1 0 0", busy, round, done); end
      start = 1'b0; abort = 1'b1;
      @(negedge clk);
      abort = 1'b0; msg_valid = 1'b0;
      #1;
      n_total++;
      if (busy !== 1'b0) begin n_bad++; $display("FAIL abort_after_restart: busy=%b want 0", busy); end
    end else begin
      msg_valid = 1'b0;
      @(negedge clk);
      #1;
      n_total++;
      if (done !== 1'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL done_single: done=%b busy=%b want 0 0", done, busy); end
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    #1;
    n_total++;
    if ({busy, done, wt_valid, wt_reg_en, msg_ready} !== 5'b0 || round !== 6'd0 || wt !== 32'd0 || w_in !== 32'd0) begin
      n_bad++; $display("FAIL reset: busy=%b done=%b vld=%b en=%b rdy=%b round=%0d wt=%h want all 0",
                        busy, done, wt_valid, wt_reg_en, msg_ready, round, wt);
    end
    n_total++;
    if (s_busy !== 1'b0 || s_done !== 1'b0 || s_round !== 6'd0) begin n_bad++; $display("FAIL reset17: busy=%b done=%b round=%0d want 0", s_busy, s_done, s_round); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_abc();
    run_block(0, -1, -1, -1, 1'b0, 1'b1);
    n_total++;
    if (obs_w[16] !== 32'h61626380) begin n_bad++; $display("FAIL abc_W16: got %h want 61626380", obs_w[16]); end
    n_total++;
    if (obs_w[17] !== 32'h000F0000) begin n_bad++; $display("FAIL abc_W17: got %h want 000f0000", obs_w[17]); end
    n_total++;
    if (obs_w[63] !== 32'h12B1EDEB) begin n_bad++; $display("FAIL abc_W63: got %h want 12b1edeb", obs_w[63]); end
  endtask

  task automatic test_stall_toggle();
    run_block(1, -1, -1, -1, 1'b0, 1'b1);
    n_total++;
    if (obs_w[63] !== 32'h12B1EDEB) begin n_bad++; $display("FAIL toggle_W63: got %h want 12b1edeb", obs_w[63]); end
  endtask

  task automatic test_msg_gap();
    run_block(2, 7, -1, -1, 1'b0, 1'b0);
  endtask

  task automatic test_abort();
    run_block(0, -1, 20, -1, 1'b0, 1'b1);
    run_block(0, -1, -1, -1, 1'b0, 1'b1);
    n_total++;
    if (obs_w[63] !== 32'h12B1EDEB) begin n_bad++; $display("FAIL abort_reload_W63: got %h want 12b1edeb", obs_w[63]); end
  endtask

  task automatic test_abort_idle();
    @(negedge clk);
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    #1;
    n_total++;
    if (busy !== 1'b0 || round !== 6'd0) begin n_bad++; $display("FAIL abort_beats_start: busy=%b round=%0d want 0 0", busy, round); end
  endtask

  task automatic test_start_held();
    run_block(2, -1, -1, -1, 1'b1, 1'b0);
  endtask

  task automatic test_reset_mid();
    run_block(0, -1, -1, 40, 1'b0, 1'b0);
  endtask

  task automatic test_short17();
    int k, cyc;
    bit rdy;
    load_msg(1'b0);
    @(negedge clk);
    s_start = 1'b1; s_msg_valid = 1'b1; s_wt_ready = 1'b0;
    @(negedge clk);
    s_start = 1'b0; k = 0; cyc = 0;
    while (k < 17 && cyc < 500) begin
      rdy = 1'($urandom_range(0, 1));
      s_wt_ready = rdy;
      s_msg_word = (k < 16) ? ref_m[k] : $urandom;
      #1;
      n_total++;
      if (s_round !== 6'(k) || s_done !== 1'b0) begin n_bad++; $display("FAIL short_round: round=%0d done=%b want %0d 0", s_round, s_done, k); end
      n_total++;
      if (s_wt !== ref_w[k] || s_wt_valid !== 1'b1) begin n_bad++; $display("FAIL short_W t=%0d: got %h vld=%b want %h 1", k, s_wt, s_wt_valid, ref_w[k]); end
      if (rdy) k++;
      @(negedge clk);
      cyc++;
    end
    n_total++;
    if (cyc >= 500) begin n_bad++; $display("FAIL short_timeout: fires=%0d want 17", k); end
    #1;
    n_total++;
    if (s_done !== 1'b1 || s_busy !== 1'b0) begin n_bad++; $display("FAIL short_done: done=%b busy=%b want 1 0", s_done, s_busy); end
    s_msg_valid = 1'b0;
    @(negedge clk);
    #1;
    n_total++;
    if (s_done !== 1'b0) begin n_bad++; $display("FAIL short_done_pulse: got %b want 0", s_done); end
  endtask

  task automatic test_back_to_back();
    for (int b = 0; b < 3; b++) run_block(2, -1, -1, -1, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_abc();
    test_stall_toggle();
    test_msg_gap();
    test_abort();
    test_abort_idle();
    test_start_held();
    test_reset_mid();
    test_short17();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/m1_wt_ctrl.md
Name: m1_wt_ctrl

Overview:
- Sequences the SHA-256 message-schedule shift register (16 × 32-bit stages; taps W[t-2], W[t-7], W[t-15], W[t-16]) for one 512-bit block.
- Rounds 0..15: forwards message words from the block buffer stream.
- Rounds 16..NUM_ROUNDS-1: computes the expanded word from the register taps.
- Drives the register's shift enable and w_in, and presents W_t per round to the compression engine over a valid/ready stream.

Parameters:
- NUM_ROUNDS, 64, total schedule words per block (legal range 17..64).

Ports:
- clk_h  input  1  core clock; all state changes on rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  begin a block; sampled only in IDLE
- abort  input  1  synchronous cancel; returns to IDLE, no done
- msg_word  input  32  message word M[t] from block buffer
- msg_valid  input  1  msg_word valid
- msg_ready  output  1  msg_word consumed this cycle
- w14_t_2  input  32  register tap W[t-2]
- w9_t_7  input  32  register tap W[t-7]
- w1_t_15  input  32  register tap W[t-15]
- w0_t_16  input  32  register tap W[t-16]
- wt_reg_en  output  1  shift enable to schedule register
- w_in  output  32  word shifted into schedule register
- wt  output  32  W_t to compression engine (equals w_in)
- wt_valid  output  1  wt valid
- wt_ready  input  1  compression engine accepts wt
- round  output  6  current index t
- busy  output  1  state != IDLE
- done  output  1  one-cycle pulse after round NUM_ROUNDS-1 accepted

Behaviour:
- Reset (async, rst_n=0): state=IDLE, round=0, done=0. Combinational outputs in IDLE: wt_reg_en=0, msg_ready=0, wt_valid=0, w_in=wt=0.
- States:
  - IDLE: start=1 -> LOAD, round=0.
  - LOAD: round 0..15.
  - EXPAND: round 16..NUM_ROUNDS-1.
- fire = wt_valid & wt_ready. wt_reg_en = fire. Each fire increments round by 1.
- LOAD:
  - w_in = msg_word; wt_valid = msg_valid; msg_ready = wt_ready.
  - fire consumes exactly one message word and shifts it in.
  - fire at round 15 -> EXPAND.
- EXPAND:
  - w_in = σ1(w14_t_2) + w9_t_7 + σ0(w1_t_15) + w0_t_16, mod 2^32.
  - σ0(x) = ROTR7 ^ ROTR18 ^ SHR3; σ1(x) = ROTR17 ^ ROTR19 ^ SHR10.
  - wt_valid = 1; msg_ready = 0.
- Last round: fire at round NUM_ROUNDS-1 -> IDLE, round=0, done=1 for exactly the next cycle.
- Latency:
  - W_t is combinational from the current register contents or msg_word; zero-cycle valid/ready paths.
  - Registered state and round only.
  - Back-to-back acceptance gives 1 word/cycle: NUM_ROUNDS cycles per block, plus 1 cycle from start to first valid.
- Stalls:
  - wt_ready=0: no fire; register, round and state hold. w_in/wt stay stable while valid.
  - LOAD with msg_valid=0: wt_valid=0, no shift.
- start while busy: ignored.
- start in the done cycle: accepted (state is IDLE), new block begins next cycle.
- abort:
  - Any non-IDLE state -> IDLE, round=0, done=0 next cycle.
  - No fire in the abort cycle: wt_reg_en forced 0, msg_ready forced 0.
  - Register contents are don't-care.
  - abort in IDLE: no effect. abort together with start in IDLE: abort wins, stay IDLE.
- rst_n deasserted mid-block: immediate return to reset values; no done.
- round never exceeds NUM_ROUNDS-1; no wrap-around within a block.

Test Plan:
- Message "abc" (M0=0x61626380, M1..M14=0, M15=0x00000018), wt_ready=1, msg_valid=1 -> 64 consecutive fires; W16=0x61626380, W17=0x000F0000, W63=0x12B1EDEB; done pulses once, the cycle after round 63 fires.
- Same message with wt_ready toggling 1/0 every cycle -> identical W sequence; wt_reg_en count=64; wt stable across stalled cycles.
- LOAD with msg_valid deasserted for 5 cycles at round 7 -> round holds at 7; msg_ready=0 seen by buffer only when wt_ready=0; no shift until msg_valid returns.
- abort asserted at round 20 -> next cycle busy=0, round=0, no done; a following start reloads from round 0 and reproduces the "abc" vectors.
- start held high across a block -> no restart mid-block; new block begins in the done cycle.
- rst_n pulsed low at round 40 -> outputs immediately at reset values; no done.
- NUM_ROUNDS=17 -> EXPAND produces only W16, then done.
